// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// slave = loader side, master = stream source / memory observer side.
interface imem_loader_if #(
   parameter int WIDTH1 = 32
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              wr;
   logic [WIDTH1-1:0] addr;
   logic [WIDTH1-1:0] wdata;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  wr,
      input  addr,
      input  wdata
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output wr,
      output addr,
      output wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian image into instruction memory
// and holds the core in reset until the image is complete.
module imem_loader #(
   parameter int WIDTH1        = 32,
   parameter int MEM_SIZE      = 1024,
   parameter int INST_POSITION = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   imem_loader_if.slave bus,
   output logic         core_hold,
   output logic         done,
   output logic         error
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [15:0] LP_MAX = 16'(MEM_SIZE - INST_POSITION);

   state_t            r_state;
   logic [15:0]       r_cnt;
   logic [15:0]       r_widx;
   logic [1:0]        r_bidx;
   logic              r_in_ready;
   logic              r_wr;
   logic [WIDTH1-1:0] r_addr;
   logic [WIDTH1-1:0] r_wdata;
   logic              r_core_hold;
   logic              r_done;
   logic              r_error;

   logic              w_xfer;
   logic [15:0]       w_count;
   logic [WIDTH1-1:0] w_slot;

   assign w_xfer  = bus.in_valid & r_in_ready;
   assign w_count = {bus.in_data, r_cnt[7:0]};
   assign w_slot  = WIDTH1'(INST_POSITION) + WIDTH1'(r_widx);

   assign bus.in_ready = r_in_ready;
   assign bus.wr       = r_wr;
   assign bus.addr     = r_addr;
   assign bus.wdata    = r_wdata;
   assign core_hold    = r_core_hold;
   assign done         = r_done;
   assign error        = r_error;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_widx      <= '0;
         r_bidx      <= '0;
         r_in_ready  <= 1'b0;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_core_hold <= 1'b1;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         // wr is a single-cycle strobe, raised only on WRITE entry
         r_wr <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_state     <= S_LEN_LO;
                  r_in_ready  <= 1'b1;
                  r_done      <= 1'b0;
                  r_error     <= 1'b0;
                  r_core_hold <= 1'b1;
               end
            end
            S_LEN_LO: begin
               if (w_xfer) begin
                  r_cnt[7:0] <= bus.in_data;
                  r_state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (w_xfer) begin
                  r_cnt <= w_count;
                  if (w_count == 16'd0) begin
                     r_state     <= S_DONE;
                     r_in_ready  <= 1'b0;
                     r_done      <= 1'b1;
                     r_core_hold <= 1'b0;
                  end else if (w_count > LP_MAX) begin
                     r_state    <= S_ERR;
                     r_in_ready <= 1'b0;
                     r_error    <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                     r_widx  <= '0;
                     r_bidx  <= '0;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_wdata[{r_bidx, 3'b000} +: 8] <= bus.in_data;
                  r_bidx <= r_bidx + 2'd1;
                  if (r_bidx == 2'd3) begin
                     r_state    <= S_WRITE;
                     r_in_ready <= 1'b0;
                     r_wr       <= 1'b1;
                     r_addr     <= w_slot << 2;
                  end
               end
            end
            S_WRITE: begin
               if ((r_widx + 16'd1) == r_cnt) begin
                  r_state     <= S_DONE;
                  r_done      <= 1'b1;
                  r_core_hold <= 1'b0;
               end else begin
                  r_widx     <= r_widx + 16'd1;
                  r_state    <= S_DATA;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic, zero, bounds, backpressure,
// mid-word reset and spurious-start scenarios.
module tb_imem_loader;
   logic clk;
   logic reset;
   logic start;
   logic core_hold;
   logic done;
   logic error;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] qa[$];
   logic [31:0] qd[$];
   logic [7:0]  t1[10];

   imem_loader_if #(.WIDTH1(32)) bus ();

   imem_loader #(
      .WIDTH1(32),
      .MEM_SIZE(1024),
      .INST_POSITION(10)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .bus(bus),
      .core_hold(core_hold),
      .done(done),
      .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.wr === 1'b1) begin
         qa.push_back(bus.addr);
         qd.push_back(bus.wdata);
      end
   end

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit gap);
      int n;
      n = 0;
      if (gap && ($urandom_range(0, 1) == 1)) @(negedge clk);
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("send_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (done !== 1'b1 && error !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_t1(input string tag);
      check({tag, "_nwr"}, 64'(qa.size()), 64'd2);
      if (qa.size() == 2) begin
         check({tag, "_a0"}, 64'(qa[0]), 64'h28);
         check({tag, "_d0"}, 64'(qd[0]), 64'h10000113);
         check({tag, "_a1"}, 64'(qa[1]), 64'h2C);
         check({tag, "_d1"}, 64'(qd[1]), 64'h3FF00093);
      end
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_hold"}, 64'(core_hold), 64'd0);
      check({tag, "_err"}, 64'(error), 64'd0);
   endtask

   task automatic run_t1(input string tag, input bit gap);
      qa.delete();
      qd.delete();
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         send(t1[i], gap);
         if (i == 5) check({tag, "_wr_rise"}, 64'(bus.wr), 64'd1);
      end
      wait_end();
      check_t1(tag);
   endtask

   initial begin
      logic [31:0] w;
      int          badw;
      t1[0] = 8'h02; t1[1] = 8'h00;
      t1[2] = 8'h13; t1[3] = 8'h01; t1[4] = 8'h00; t1[5] = 8'h10;
      t1[6] = 8'h93; t1[7] = 8'h00; t1[8] = 8'hF0; t1[9] = 8'h3F;
      reset = 1'b0;
      start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);

      check("rst_wr", 64'(bus.wr), 64'd0);
      check("rst_addr", 64'(bus.addr), 64'd0);
      check("rst_wdata", 64'(bus.wdata), 64'd0);
      check("rst_rdy", 64'(bus.in_ready), 64'd0);
      check("rst_hold", 64'(core_hold), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(error), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Test 1: basic load
      run_t1("t1", 1'b0);

      // Test 2: zero count
      qa.delete();
      qd.delete();
      pulse_start();
      check("t2_done_clr", 64'(done), 64'd0);
      check("t2_hold_set", 64'(core_hold), 64'd1);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      check("t2_done", 64'(done), 64'd1);
      check("t2_hold", 64'(core_hold), 64'd0);
      repeat (2) @(negedge clk);
      check("t2_nwr", 64'(qa.size()), 64'd0);

      // Test 3a: maximum legal count fills up to the last slot
      qa.delete();
      qd.delete();
      pulse_start();
      send(8'hF6, 1'b0);
      send(8'h03, 1'b0);
      for (int k = 0; k < 1014; k++) begin
         w = 32'(k) * 32'h9E3779B1;
         for (int j = 0; j < 4; j++) send(w[8*j +: 8], 1'b0);
      end
      wait_end();
      check("t3a_nwr", 64'(qa.size()), 64'd1014);
      badw = 0;
      if (qa.size() == 1014) begin
         for (int k = 0; k < 1014; k++) begin
            w = 32'(k) * 32'h9E3779B1;
            if (qa[k] !== 32'((10 + k) * 4) || qd[k] !== w) badw++;
         end
         check("t3a_last_addr", 64'(qa[1013]), 64'hFFC);
      end
      check("t3a_badwords", 64'(badw), 64'd0);
      check("t3a_done", 64'(done), 64'd1);
      check("t3a_hold", 64'(core_hold), 64'd0);

      // Test 3b: one past the limit
      qa.delete();
      qd.delete();
      pulse_start();
      send(8'hF7, 1'b0);
      send(8'h03, 1'b0);
      check("t3b_err", 64'(error), 64'd1);
      check("t3b_hold", 64'(core_hold), 64'd1);
      check("t3b_done", 64'(done), 64'd0);
      check("t3b_rdy", 64'(bus.in_ready), 64'd0);
      repeat (5) @(negedge clk);
      check("t3b_err_hold", 64'(error), 64'd1);
      check("t3b_nwr", 64'(qa.size()), 64'd0);

      // Test 3c: recovery from ERR
      run_t1("t3c", 1'b0);

      // Test 4: backpressure
      run_t1("t4", 1'b1);

      // Test 5: reset mid-word
      qa.delete();
      qd.delete();
      pulse_start();
      for (int i = 0; i < 4; i++) send(t1[i], 1'b0);
      reset = 1'b0;
      #1;
      check("t5_wr", 64'(bus.wr), 64'd0);
      check("t5_addr", 64'(bus.addr), 64'd0);
      check("t5_wdata", 64'(bus.wdata), 64'd0);
      check("t5_rdy", 64'(bus.in_ready), 64'd0);
      check("t5_hold", 64'(core_hold), 64'd1);
      check("t5_done", 64'(done), 64'd0);
      repeat (3) @(negedge clk);
      check("t5_nwr", 64'(qa.size()), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      run_t1("t5r", 1'b0);

      // Test 6: spurious start during DATA
      qa.delete();
      qd.delete();
      pulse_start();
      for (int i = 0; i < 4; i++) send(t1[i], 1'b0);
      pulse_start();
      check("t6_rdy", 64'(bus.in_ready), 64'd1);
      for (int i = 4; i < 10; i++) send(t1[i], 1'b0);
      wait_end();
      check_t1("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
